// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ byte producers.
// One byte per grant; follows tx_busy through each byte and flags a transmitter that never responds.
module uart_tx_arbiter #(
  parameter int N_REQ     = 2,
  parameter int BUSY_WAIT = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [8*N_REQ-1:0]       req_data,
  output logic [N_REQ-1:0]         ack,
  output logic                     tx_send_req,
  output logic [7:0]               tx_data,
  input  logic                     tx_busy,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     err_timeout
);

  localparam int IDW = $clog2(N_REQ);
  localparam int CW  = $clog2(BUSY_WAIT + 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             send_q, send_d;
  logic [7:0]       data_q, data_d;
  logic [IDW-1:0]   gid_q, gid_d;
  logic             err_q, err_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             found;
  logic [IDW-1:0]   pick_id;
  logic [7:0]       pick_byte;

  assign ack         = ack_q;
  assign tx_send_req = send_q;
  assign tx_data     = data_q;
  assign grant_id    = gid_q;
  assign err_timeout = err_q;

  // Scan starts just after the last winner, so the last winner has lowest priority.
  always_comb begin
    found     = 1'b0;
    pick_id   = gid_q;
    pick_byte = 8'h00;
    for (int i = 1; i <= N_REQ; i++) begin
      if (!found && req[(int'(gid_q) + i) % N_REQ]) begin
        found     = 1'b1;
        pick_id   = IDW'((int'(gid_q) + i) % N_REQ);
        pick_byte = req_data[8*((int'(gid_q) + i) % N_REQ) +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ack_d   = '0;
    send_d  = 1'b0;
    data_d  = data_q;
    gid_d   = gid_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (!tx_busy && found) begin
          data_d  = pick_byte;
          gid_d   = pick_id;
          ack_d   = N_REQ'(1) << pick_id;
          send_d  = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        cnt_d   = '0;
        state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (tx_busy) begin
          state_d = WAIT_LO;
        end else if (cnt_q == CW'(BUSY_WAIT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_LO: begin
        if (!tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ack_q   <= '0;
      send_q  <= 1'b0;
      data_q  <= 8'h00;
      gid_q   <= IDW'(N_REQ - 1);
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      send_q  <= send_d;
      data_q  <= data_d;
      gid_q   <= gid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized traffic, all checked
// cycle by cycle against a transaction-level reference model of the arbitration rules.
module tb_uart_tx_arbiter;

  localparam int N_REQ     = 2;
  localparam int BUSY_WAIT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [15:0] req_data;
  logic [1:0]  ack;
  logic        tx_send_req;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic [0:0]  grant_id;
  logic        err_timeout;

  int n_chk = 0;
  int n_err = 0;

  uart_tx_arbiter #(.N_REQ(N_REQ), .BUSY_WAIT(BUSY_WAIT)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .ack(ack),
    .tx_send_req(tx_send_req), .tx_data(tx_data), .tx_busy(tx_busy),
    .grant_id(grant_id), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int rr_pick(input int last, input logic [1:0] r);
    for (int i = 1; i <= N_REQ; i++)
      if (r[(last + i) % N_REQ]) return (last + i) % N_REQ;
    return -1;
  endfunction

  // Reference model: one outstanding byte at a time. After a grant in cycle A
  // the arbiter is free again once busy has been seen high within A+1..A+BUSY_WAIT
  // and then seen low, or straight after A+BUSY_WAIT if busy never rose.
  logic [1:0] exp_ack;
  logic       exp_send;
  logic [7:0] exp_data;
  logic [0:0] exp_gid;
  logic       exp_err;
  bit         mdl_valid = 1'b0;
  bit         m_idle = 1'b1;
  bit         m_hi;
  int         m_t;
  int         m_gid;
  int         k;

  always @(negedge clk) begin
    if (mdl_valid) begin
      chk("ack", 32'(ack), 32'(exp_ack));
      chk("tx_send_req", 32'(tx_send_req), 32'(exp_send));
      chk("tx_data", 32'(tx_data), 32'(exp_data));
      chk("grant_id", 32'(grant_id), 32'(exp_gid));
      chk("err_timeout", 32'(err_timeout), 32'(exp_err));
    end
    if (reset) begin
      exp_ack = '0; exp_send = 1'b0; exp_data = 8'h00; exp_err = 1'b0;
      m_gid = N_REQ - 1; exp_gid = 1'(m_gid); m_idle = 1'b1; mdl_valid = 1'b1;
    end else if (mdl_valid) begin
      exp_ack = '0; exp_send = 1'b0;
      if (m_idle) begin
        k = rr_pick(m_gid, req);
        if (!tx_busy && k >= 0) begin
          m_gid = k; exp_gid = 1'(k); exp_ack = 2'(1 << k); exp_send = 1'b1;
          exp_data = req_data[8*k +: 8];
          m_idle = 1'b0; m_t = 0; m_hi = 1'b0;
        end
      end else begin
        if (m_t == 0) begin
        end else if (!m_hi) begin
          if (tx_busy) m_hi = 1'b1;
          else if (m_t == BUSY_WAIT) begin exp_err = 1'b1; m_idle = 1'b1; end
        end else if (!tx_busy) begin
          m_idle = 1'b1;
        end
        m_t++;
      end
    end
  end

  logic [1:0] snap_ack;
  logic       snap_send;
  always @(negedge clk) begin
    snap_ack  = ack;
    snap_send = tx_send_req;
  end

  // Transmitter and requester behaviour, applied 1 time unit after each rising edge.
  bit tx_dead = 1'b0, rand_mode = 1'b0, auto_req = 1'b0, rand_rst = 1'b0, force_busy = 1'b0;
  int dly_fix = 0, len_fix = 10;
  bit tx_pend = 1'b0;
  int tx_dly = 0, tx_len = 0, tx_left = 0;
  bit busy_line = 1'b0;

  task automatic step();
    @(posedge clk); #1;
    if (snap_send && !(tx_dead || (rand_mode && $urandom % 10 == 0))) begin
      tx_pend = 1'b1;
      if (dly_fix >= 0) tx_dly = dly_fix;
      else if ($urandom % 8 == 0) tx_dly = int'($urandom_range(BUSY_WAIT + 2, BUSY_WAIT - 2));
      else tx_dly = int'($urandom % 4);
      tx_len = (len_fix > 0) ? len_fix : int'($urandom_range(12, 1));
    end
    if (tx_pend) begin
      if (tx_dly == 0) begin tx_pend = 1'b0; tx_left = tx_len; end
      else tx_dly--;
    end
    if (tx_left > 0) begin tx_left--; busy_line = 1'b1; end
    else busy_line = 1'b0;
    tx_busy = busy_line | force_busy;
    if (auto_req) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (snap_ack[i]) begin
          req[i] = $urandom % 2;
          req_data[8*i +: 8] = 8'($urandom);
        end else if (!req[i] && $urandom % 4 == 0) begin
          req[i] = 1'b1;
          req_data[8*i +: 8] = 8'($urandom);
        end
      end
    end
    if (rand_rst) reset = ($urandom % 150 == 0);
  endtask

  task automatic do_reset();
    reset = 1'b1; step(); step(); reset = 1'b0;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_send(input string tag, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      step();
      if (tx_send_req) ok = 1'b1;
    end
    if (!ok) chk(tag, 32'(0), 32'(1));
  endtask

  logic [7:0] t2_data [4];
  logic [1:0] t2_ack [4];
  logic [7:0] t2_exp_d [4];
  logic [1:0] t2_exp_a [4];
  int         cnt;
  int         ack0_cnt;
  bit         ok;

  initial begin
    reset = 1'b1; req = '0; req_data = '0; tx_busy = 1'b0;
    t2_exp_d[0] = 8'hAA; t2_exp_d[1] = 8'h55; t2_exp_d[2] = 8'hAA; t2_exp_d[3] = 8'h55;
    t2_exp_a[0] = 2'b01; t2_exp_a[1] = 2'b10; t2_exp_a[2] = 2'b01; t2_exp_a[3] = 2'b10;
    step(); step();
    chk("rst_grant_id", 32'(grant_id), 32'(1));
    chk("rst_ack", 32'(ack), 32'(0));
    reset = 1'b0;

    // First byte: one-cycle latency from req to ack/send.
    req = 2'b01; req_data = 16'h0041;
    step();
    chk("t1_ack", 32'(ack), 32'(2'b01));
    chk("t1_send", 32'(tx_send_req), 32'(1));
    chk("t1_data", 32'(tx_data), 32'(8'h41));
    chk("t1_gid", 32'(grant_id), 32'(0));
    req = 2'b00;
    idle_steps(30);

    // Both requesters held high: strict alternation.
    do_reset();
    req = 2'b11; req_data = 16'h55AA;
    cnt = 0;
    for (int i = 0; i < 300 && cnt < 4; i++) begin
      step();
      if (tx_send_req) begin t2_data[cnt] = tx_data; t2_ack[cnt] = ack; cnt++; end
    end
    req = 2'b00;
    chk("t2_count", 32'(cnt), 32'(4));
    for (int i = 0; i < cnt; i++) begin
      chk("t2_data", 32'(t2_data[i]), 32'(t2_exp_d[i]));
      chk("t2_ack", 32'(t2_ack[i]), 32'(t2_exp_a[i]));
    end
    idle_steps(30);

    // Busy held at reset release: grant waits, then follows one cycle after busy falls.
    reset = 1'b1; force_busy = 1'b1; tx_busy = 1'b1; req = 2'b01; req_data = 16'h0033;
    step(); step(); reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_noack", 32'(ack), 32'(0));
    end
    force_busy = 1'b0; tx_busy = busy_line;
    chk("t3_pre", 32'(ack), 32'(0));
    step();
    chk("t3_ack", 32'(ack), 32'(2'b01));
    chk("t3_data", 32'(tx_data), 32'(8'h33));
    req = 2'b00;
    idle_steps(30);

    // Transmitter never responds: timeout, then the next request still gets through.
    do_reset();
    tx_dead = 1'b1; req = 2'b01; req_data = 16'h0077;
    wait_send("t4_send", ok);
    req = 2'b00;
    idle_steps(BUSY_WAIT);
    chk("t4_err_early", 32'(err_timeout), 32'(0));
    step();
    chk("t4_err", 32'(err_timeout), 32'(1));
    tx_dead = 1'b0; req = 2'b10; req_data = 16'h9900;
    step();
    chk("t4_next_ack", 32'(ack), 32'(2'b10));
    chk("t4_next_data", 32'(tx_data), 32'(8'h99));
    req = 2'b00;
    idle_steps(30);
    chk("t4_sticky", 32'(err_timeout), 32'(1));

    // Reset while waiting for busy to fall.
    do_reset();
    req = 2'b01; req_data = 16'h0012;
    wait_send("t5_send", ok);
    req = 2'b00;
    step(); step();
    reset = 1'b1;
    step();
    chk("t5_ack", 32'(ack), 32'(0));
    chk("t5_send", 32'(tx_send_req), 32'(0));
    chk("t5_data", 32'(tx_data), 32'(0));
    chk("t5_gid", 32'(grant_id), 32'(1));
    chk("t5_err", 32'(err_timeout), 32'(0));
    reset = 1'b0; req = 2'b11; req_data = 16'h3412;
    wait_send("t5_regrant", ok);
    chk("t5_regrant_ack", 32'(ack), 32'(2'b01));
    req = 2'b00;
    idle_steps(30);

    // Handover: req1 rises on the edge req0 drops after its ack.
    do_reset();
    req = 2'b01; req_data = 16'h2211;
    wait_send("t6_send", ok);
    chk("t6_ack0", 32'(ack), 32'(2'b01));
    step();
    req = 2'b10;
    ack0_cnt = 0; ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      step();
      if (ack[0]) ack0_cnt++;
      if (tx_send_req) ok = 1'b1;
    end
    chk("t6_found", 32'(ok), 32'(1));
    chk("t6_ack1", 32'(ack), 32'(2'b10));
    chk("t6_data", 32'(tx_data), 32'(8'h22));
    chk("t6_no_dup0", 32'(ack0_cnt), 32'(0));
    req = 2'b00;
    idle_steps(30);

    // Randomized traffic with late/absent busy and occasional resets.
    do_reset();
    dly_fix = -1; len_fix = -1; rand_mode = 1'b1; auto_req = 1'b1; rand_rst = 1'b1;
    idle_steps(4000);
    auto_req = 1'b0; rand_rst = 1'b0; reset = 1'b0; req = 2'b00;
    idle_steps(40);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
